// File: rtl/tx_sched_pkg.sv
// Shared types and defaults for the Ethernet TX segment scheduler.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } tx_state_e;

  localparam logic [2:0] SEL_R = 3'd0;
  localparam logic [2:0] SEL_B = 3'd1;
  localparam logic [2:0] SEL_G = 3'd2;

  localparam int unsigned SEG_BYTES_DEF    = 1080;
  localparam int unsigned FRAME_PIXELS_DEF = 921600;
  localparam int unsigned RD_LAT_DEF       = 2;

  function automatic logic [2:0] next_sel(logic [2:0] sel);
    case (sel)
      SEL_R:   return SEL_B;
      SEL_B:   return SEL_G;
      default: return SEL_R;
    endcase
  endfunction

  // Operands are already below modulus, so a single conditional subtract is enough.
  function automatic logic [23:0] wrap_add(logic [23:0] a, logic [23:0] b, logic [23:0] modulus);
    logic [24:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, modulus}) return 24'(sum - {1'b0, modulus});
    return sum[23:0];
  endfunction

endpackage

// File: rtl/tx_sched_delay.sv
// Fixed-depth shift register that aligns read-side controls with the memory read latency.
module tx_sched_delay #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] pipe_q [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < Depth; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/tx_segment_scheduler.sv
// Per-segment read sequencer for the TX payload path (VRAM first send, bram_1080 replay).
// Optional replay path enabled by defining TX_SCHED_REPLAY_EN.
module tx_segment_scheduler
  import tx_sched_pkg::*;
#(
  parameter int unsigned SEG_BYTES    = SEG_BYTES_DEF,
  parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int unsigned RD_LAT       = RD_LAT_DEF
) (
  input  logic        clk125MHz,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  txid,
  input  logic [7:0]  segment_num,
  input  logic [23:0] startaddr,
  output logic        busy,
  output logic        done,
  output logic        start_err,
  output logic [23:0] addrb,
  output logic [2:0]  vramaddr_c,
  output logic [12:0] count_for_bram,
  output logic        count_for_bram_en,
  output logic [12:0] count_for_bram_b,
  output logic        byte_valid,
  output logic        data_user,
  output logic [23:0] lastaddr
);

  localparam logic [12:0] LastK     = 13'(SEG_BYTES - 1);
  localparam logic [23:0] LastPix   = 24'(FRAME_PIXELS - 1);
  localparam logic [23:0] FramePix  = 24'(FRAME_PIXELS);
  localparam logic [23:0] SegPix    = 24'(SEG_BYTES / 3);
  localparam logic [7:0]  LastDrain = 8'(RD_LAT - 1);
  localparam int unsigned DlyW      = 18;

  tx_state_e   state_q, state_d;
  logic [12:0] k_q, k_d;
  logic [2:0]  sel_q, sel_d;
  logic [23:0] base_q, base_d;
  logic [23:0] addr_q, addr_d;
  logic [23:0] lastaddr_q, lastaddr_d;
  logic [7:0]  drain_q, drain_d;
  logic        replay_q, replay_d;
  logic        start_err_q, start_err_d;

  logic            rd;
  logic            wb;
  logic [DlyW-1:0] dly_d, dly_q;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    sel_d       = sel_q;
    base_d      = base_q;
    addr_d      = addr_q;
    lastaddr_d  = lastaddr_q;
    drain_d     = drain_q;
    replay_d    = replay_q;
    start_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (txid == 8'd0) begin
            start_err_d = 1'b1;
          end else begin
            state_d = StRead;
            k_d     = '0;
            sel_d   = SEL_R;
            base_d  = (segment_num == 8'd0) ? 24'd0 : startaddr;
            addr_d  = base_d;
`ifdef TX_SCHED_REPLAY_EN
            replay_d = (txid >= 8'd2);
`else
            replay_d = 1'b0;
`endif
          end
        end
      end
      StRead: begin
        k_d   = k_q + 13'd1;
        sel_d = next_sel(sel_q);
        // Pixel address advances once all three colour bytes have been requested.
        if (!replay_q && sel_q == SEL_G) addr_d = (addr_q == LastPix) ? 24'd0 : addr_q + 24'd1;
        if (k_q == LastK) begin
          state_d = StDrain;
          drain_d = '0;
          if (!replay_q) lastaddr_d = wrap_add(base_q, SegPix, FramePix);
        end
      end
      StDrain: begin
        if (drain_q == LastDrain) state_d = StDone;
        else drain_d = drain_q + 8'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk125MHz) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      sel_q       <= SEL_R;
      base_q      <= '0;
      addr_q      <= '0;
      drain_q     <= '0;
      replay_q    <= 1'b0;
      start_err_q <= 1'b0;
      // An aborted segment must not disturb the resume point; an idle reset clears it.
      lastaddr_q  <= (state_q == StIdle) ? 24'd0 : lastaddr_q;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      sel_q       <= sel_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      drain_q     <= drain_d;
      replay_q    <= replay_d;
      start_err_q <= start_err_d;
      lastaddr_q  <= lastaddr_d;
    end
  end

  assign rd    = (state_q == StRead);
  assign wb    = rd && !replay_q;
  assign dly_d = {rd ? sel_q : SEL_R, rd, wb, wb ? k_q : 13'd0};

  tx_sched_delay #(
    .Width(DlyW),
    .Depth(RD_LAT)
  ) u_delay (
    .clk_i(clk125MHz),
    .rst_i(rst),
    .d_i  (dly_d),
    .q_o  (dly_q)
  );

  assign {vramaddr_c, byte_valid, count_for_bram_en, count_for_bram} = dly_q;

`ifdef TX_SCHED_REPLAY_EN
  assign count_for_bram_b = (rd && replay_q) ? k_q : 13'd0;
`else
  assign count_for_bram_b = 13'd0;
`endif

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign data_user = rd || (state_q == StDrain);
  assign start_err = start_err_q;
  assign addrb     = addr_q;
  assign lastaddr  = lastaddr_q;

endmodule

// File: tb/tb_tx_segment_scheduler.sv
// Self-checking bench for tx_segment_scheduler against a cycle-offset reference model.
module tb_tx_segment_scheduler;

  localparam int SEG   = 1080;
  localparam int FRAME = 921600;
  localparam int RDL   = 2;

  logic        clk125MHz = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  txid = '0;
  logic [7:0]  segment_num = '0;
  logic [23:0] startaddr = '0;
  logic        busy, done, start_err, count_for_bram_en, byte_valid, data_user;
  logic [23:0] addrb, lastaddr;
  logic [2:0]  vramaddr_c;
  logic [12:0] count_for_bram, count_for_bram_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] exp_last = '0;

  always #4 clk125MHz = ~clk125MHz;

  tx_segment_scheduler dut (
    .clk125MHz        (clk125MHz),
    .rst              (rst),
    .start            (start),
    .txid             (txid),
    .segment_num      (segment_num),
    .startaddr        (startaddr),
    .busy             (busy),
    .done             (done),
    .start_err        (start_err),
    .addrb            (addrb),
    .vramaddr_c       (vramaddr_c),
    .count_for_bram   (count_for_bram),
    .count_for_bram_en(count_for_bram_en),
    .count_for_bram_b (count_for_bram_b),
    .byte_valid       (byte_valid),
    .data_user        (data_user),
    .lastaddr         (lastaddr)
  );

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk125MHz);
  endtask

  // Called at a negedge; the start is sampled at the following posedge (edge T).
  // Cycle c is the c-th cycle after T. Returns at the negedge of the IDLE cycle after done.
  task automatic run_segment(input logic [7:0] tid, input logic [7:0] snum,
                             input logic [23:0] saddr, input int inj_at, input int rst_at);
    bit          repl, first;
    logic [23:0] base, new_last;
    logic [58:0] all_obs;
`ifdef TX_SCHED_REPLAY_EN
    repl = (tid >= 8'd2);
`else
    repl = 1'b0;
`endif
    first    = !repl;
    base     = (snum == 8'd0) ? 24'd0 : saddr;
    new_last = first ? 24'((int'(base) + SEG / 3) % FRAME) : exp_last;
    start = 1'b1; txid = tid; segment_num = snum; startaddr = saddr;
    @(negedge clk125MHz);
    start = 1'b0;
    for (int c = 1; c <= SEG + RDL + 2; c++) begin
      bit          rd, vw;
      int          k, j;
      logic [5:0]  exp_ctrl, obs_ctrl;
      rd = (c <= SEG);
      vw = (c >= 1 + RDL) && (c <= SEG + RDL);
      k  = c - 1;
      j  = c - 1 - RDL;
      exp_ctrl = {c <= SEG + RDL + 1, c == SEG + RDL + 1, 1'b0, vw, c <= SEG + RDL, vw && first};
      obs_ctrl = {busy, done, start_err, byte_valid, data_user, count_for_bram_en};
      n_checks++;
      if (obs_ctrl !== exp_ctrl) begin
        n_fail++;
        $display("FAIL ctrl c=%0d {busy,done,err,valid,user,wen}: got %b want %b", c, obs_ctrl, exp_ctrl);
      end
      if (rd) begin
        logic [23:0] ea;
        logic [12:0] eb;
        ea = first ? 24'((int'(base) + k / 3) % FRAME) : base;
        eb = repl ? 13'(k) : 13'd0;
        n_checks++;
        if (addrb !== ea) begin
          n_fail++;
          $display("FAIL addrb c=%0d: got %0d want %0d", c, addrb, ea);
        end
        n_checks++;
        if (count_for_bram_b !== eb) begin
          n_fail++;
          $display("FAIL count_for_bram_b c=%0d: got %0d want %0d", c, count_for_bram_b, eb);
        end
      end
      if (vw) begin
        n_checks++;
        if (vramaddr_c !== 3'(j % 3)) begin
          n_fail++;
          $display("FAIL vramaddr_c c=%0d: got %0d want %0d", c, vramaddr_c, j % 3);
        end
        if (first) begin
          n_checks++;
          if (count_for_bram !== 13'(j)) begin
            n_fail++;
            $display("FAIL count_for_bram c=%0d: got %0d want %0d", c, count_for_bram, j);
          end
        end
      end
      if (c < SEG) begin
        n_checks++;
        if (lastaddr !== exp_last) begin
          n_fail++;
          $display("FAIL lastaddr_hold c=%0d: got %0d want %0d", c, lastaddr, exp_last);
        end
      end else if (c > SEG) begin
        n_checks++;
        if (lastaddr !== new_last) begin
          n_fail++;
          $display("FAIL lastaddr_new c=%0d: got %0d want %0d", c, lastaddr, new_last);
        end
      end
      start = (c == inj_at);
      if (c == inj_at) txid = 8'($urandom_range(255, 0));
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk125MHz);
        rst = 1'b0;
        all_obs = {busy, done, start_err, addrb, vramaddr_c, count_for_bram, count_for_bram_en,
                   count_for_bram_b, byte_valid, data_user};
        n_checks++;
        if (all_obs !== '0) begin
          n_fail++;
          $display("FAIL mid_reset_outputs: got %h want 0", all_obs);
        end
        n_checks++;
        if (lastaddr !== exp_last) begin
          n_fail++;
          $display("FAIL mid_reset_lastaddr: got %0d want %0d", lastaddr, exp_last);
        end
        return;
      end
      if (c < SEG + RDL + 2) @(negedge clk125MHz);
    end
    exp_last = new_last;
  endtask

  task automatic test_reset();
    logic [82:0] obs;
    rst = 1'b1;
    idle(3);
    obs = {busy, done, start_err, addrb, vramaddr_c, count_for_bram, count_for_bram_en,
           count_for_bram_b, byte_valid, data_user, lastaddr};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
    rst = 1'b0;
    exp_last = '0;
    idle(1);
  endtask

  task automatic test_first_tx();
    run_segment(8'd1, 8'd0, 24'd500, 0, 0);
    idle(2);
  endtask

  task automatic test_replay();
    run_segment(8'd2, 8'd3, 24'd360, 0, 0);
    idle(2);
  endtask

  task automatic test_wrap();
    run_segment(8'd1, 8'd5, 24'd921500, 0, 0);
    idle(2);
  endtask

  task automatic test_start_err();
    start = 1'b1; txid = 8'd0;
    @(negedge clk125MHz);
    start = 1'b0;
    n_checks++;
    if ({start_err, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL start_err_pulse {err,busy}: got %b want 10", {start_err, busy});
    end
    @(negedge clk125MHz);
    n_checks++;
    if ({start_err, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL start_err_clear {err,busy}: got %b want 00", {start_err, busy});
    end
    idle(1);
  endtask

  task automatic test_ignored_start();
    run_segment(8'd1, 8'd7, exp_last, 100, 0);
    idle(2);
  endtask

  task automatic test_mid_reset();
    run_segment(8'd1, 8'd9, 24'd1234, 0, 401);
    idle(2);
    run_segment(8'd1, 8'd10, exp_last, 0, 0);
    idle(1);
  endtask

  task automatic test_back_to_back();
    run_segment(8'd1, 8'd11, exp_last, 0, 0);
    run_segment(8'd3, 8'd12, exp_last, 0, 0);
    idle(1);
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      logic [7:0]  tid, snum;
      logic [23:0] sa;
      tid  = 8'($urandom_range(255, 1));
      snum = ($urandom_range(3, 0) == 0) ? 8'd0 : 8'($urandom_range(255, 1));
      sa   = ($urandom_range(1, 0) == 1) ? 24'($urandom_range(FRAME - 1, FRAME - 400))
                                         : 24'($urandom_range(FRAME - 1, 0));
      run_segment(tid, snum, sa, 0, 0);
      idle($urandom_range(3, 0));
    end
  endtask

  initial begin
    @(negedge clk125MHz);
    test_reset();
    test_first_tx();
    test_replay();
    test_wrap();
    test_start_err();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_segment_scheduler.md
# tx_segment_scheduler

Sequencer for the Ethernet TX payload path on the 125 MHz clock. Per segment request it drives the VRAM/bram_1080 read-address side of `tx_memory_control`: pixel addresses, R/G/B byte selector, the copy-into-bram_1080 write counter, the replay read counter and the `data_user` frame strobe. It also computes `lastaddr` so the next segment continues where this one stopped. It sits between the frame builder (which issues `start` per UDP segment) and `tx_memory_control`.

## Interface
- `SEG_BYTES`, 1080: payload bytes per segment; must be a multiple of 3 and ≤ 8191.
- `FRAME_PIXELS`, 921600: pixels per frame; VRAM pixel addresses wrap modulo this.
- `RD_LAT`, 2: read latency in cycles, from address out to `doutb` valid (VRAM and bram_1080 both).

Ports:
- `clk125MHz`  in  1  Ethernet TX clock; the only clock.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle segment request; accepted only in IDLE.
- `txid`  in  8  1 = first transmission (read VRAM); ≥2 = replay from bram_1080; 0 = invalid.
- `segment_num`  in  8  0 = first segment of frame (base address forced to 0).
- `startaddr`  in  24  segment base pixel address, from `tx_memory_control`.
- `busy`  out  1  high from acceptance through DONE.
- `done`  out  1  one-cycle pulse at end of segment.
- `start_err`  out  1  one-cycle pulse when `start` is seen with `txid==0`.
- `addrb`  out  24  VRAM read pixel address.
- `vramaddr_c`  out  3  byte selector aligned with `doutb`: 0 = R, 1 = B, 2 = G.
- `count_for_bram`  out  13  bram_1080 write address.
- `count_for_bram_en`  out  1  bram_1080 write enable (first transmission only).
- `count_for_bram_b`  out  13  bram_1080 replay read address.
- `byte_valid`  out  1  `doutb` carries a payload byte this cycle.
- `data_user`  out  1  payload-window strobe; its falling edge latches `lastaddr` into `startaddr`.
- `lastaddr`  out  24  base address for the next segment.

## Operation
- States: IDLE → READ (SEG_BYTES cycles) → DRAIN (RD_LAT cycles) → DONE (1 cycle) → IDLE.
- Acceptance is IDLE & `start` & `txid≠0`. On acceptance, latch `txid` and set base = (`segment_num==0`) ? 0 : `startaddr`.
- IDLE & `start` & `txid==0`: pulse `start_err` and stay in IDLE.
- `start` in any state other than IDLE is ignored. It is not queued and does not raise `start_err`.
- READ, first transmission:
  - Byte index k runs 0..SEG_BYTES-1.
  - `addrb` = (base + k/3) mod FRAME_PIXELS; the same address is held for 3 cycles.
  - The wrap is computed by compare-and-subtract, with no divider or modulo operator.
- READ, replay:
  - `count_for_bram_b` = k.
  - `addrb` is held at base.
- Selector `vramaddr_c` sequence: 0, 1, 2 repeating, delayed RD_LAT cycles so that it is aligned with `doutb`.
- Write-back, first transmission only:
  - `count_for_bram_en` is high for exactly SEG_BYTES cycles, starting RD_LAT cycles after the first read.
  - `count_for_bram` = 0..SEG_BYTES-1, aligned with the enable.
- `byte_valid`: the READ window delayed by RD_LAT, on both paths.
- `data_user`: high from the first READ cycle through the last DRAIN cycle; falls entering DONE.
- `lastaddr`:
  - First transmission: updated to (base + SEG_BYTES/3) mod FRAME_PIXELS on the last READ cycle.
  - Replay: unchanged, so `startaddr` is relatched to its existing value.

## Timing
- Reset values: all outputs 0; state IDLE.
- `rst` mid-segment: return to IDLE next cycle, all outputs to 0. No `done` pulse and no `lastaddr` update.
- `start` sampled at edge T → first READ cycle at T+1 (`busy` high from T+1).
- First `byte_valid` at T+1+RD_LAT; last at T+SEG_BYTES+RD_LAT.
- `done` at T+SEG_BYTES+RD_LAT+1; IDLE at the next cycle. A new `start` is accepted in that same cycle.
- `lastaddr` is stable at least RD_LAT cycles before `data_user` falls.
- Wrap: base = FRAME_PIXELS-1 → `addrb` reads FRAME_PIXELS-1 for 3 cycles, then 0, 1, …

## Configuration
- `TX_SCHED_REPLAY_EN`
  - Defined: `txid≥2` uses the bram_1080 replay path as above.
  - Undefined: every valid `txid` takes the first-transmission path (VRAM read, write-back, `lastaddr` update); `count_for_bram_b` is tied to 0.

## Structure
- Package `tx_sched_pkg`: state enumeration (IDLE/READ/DRAIN/DONE), selector codes SEL_R=0, SEL_B=1, SEL_G=2, and default constants for SEG_BYTES, FRAME_PIXELS and RD_LAT.
- Sub-module `tx_sched_delay`: parameterized shift register, depth RD_LAT. It aligns `vramaddr_c`, `byte_valid`, `count_for_bram_en` and `count_for_bram` to the read latency.

## Test plan
- Reset, then `start`, `txid=1`, `segment_num=0`, `startaddr=500`:
  - `addrb` runs 0,0,0,1,1,1…359.
  - 1080 `byte_valid` cycles; 1080 write-backs at addresses 0..1079.
  - `lastaddr=360`; `done` at T+1083.
- `txid=2`, `segment_num=3`, `startaddr=360`:
  - `count_for_bram_b` runs 0..1079.
  - `count_for_bram_en` never high; `lastaddr` unchanged.
- `txid=1`, `segment_num=5`, `startaddr=921500`: `addrb` wraps after 921599 to 0; `lastaddr=260`.
- `start` with `txid=0` → one `start_err` pulse, `busy` stays 0. `start` pulsed mid-READ → ignored, exactly one `done`.
- `rst` asserted at byte 400 of a first transmission:
  - Next cycle all outputs are 0 and `lastaddr` keeps its previous value.
  - A subsequent `start` completes normally.
- Back-to-back: `start` in the cycle after `done` → accepted, with no gap beyond one IDLE cycle.
